// File: rtl/move_sequencer.sv
// Turn controller for the Connect-4 datapath: owns the 6x7 board and turn state, drives the
// external move validator and writes pieces. board is flattened as board[(row*7+col)*2 +: 2].
module move_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 500_000_000,
    parameter logic [1:0]  FIRST_PLAYER   = 2'b01
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        move_req,
    input  logic [2:0]  move_col,
    input  logic        game_over,
    output logic [2:0]  val_col,
    input  logic        val_valid,
    input  logic [2:0]  val_row,
    output logic [83:0] board,
    output logic [1:0]  cur_player,
    output logic        busy,
    output logic        move_done,
    output logic        move_invalid,
    output logic        turn_timeout,
    output logic [2:0]  last_row,
    output logic [2:0]  last_col,
    output logic [5:0]  move_count,
    output logic        board_full
);

    localparam int unsigned TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [5:0] CELLS = 6'd42;

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StWait   = 3'd1;
    localparam logic [2:0] StCheck  = 3'd2;
    localparam logic [2:0] StWrite  = 3'd3;
    localparam logic [2:0] StSettle = 3'd4;
    localparam logic [2:0] StOver   = 3'd5;

    logic [2:0]                state_q, state_d;
    logic [5:0][6:0][1:0]      board_q, board_d;
    logic [1:0]                cur_q, cur_d;
    logic [1:0]                other_player;
    logic [5:0]                count_q, count_d;
    logic [2:0]                last_row_q, last_row_d;
    logic [2:0]                last_col_q, last_col_d;
    logic [2:0]                val_col_q, val_col_d;
    logic [2:0]                row_q, row_d;
    logic [TIMER_W-1:0]        timer_q, timer_d;
    logic                      done_q, done_d;
    logic                      invalid_q, invalid_d;
    logic                      timeout_q, timeout_d;

    assign other_player = (cur_q == 2'b01) ? 2'b10 : 2'b01;

    always_comb begin
        state_d    = state_q;
        board_d    = board_q;
        cur_d      = cur_q;
        count_d    = count_q;
        last_row_d = last_row_q;
        last_col_d = last_col_q;
        val_col_d  = val_col_q;
        row_d      = row_q;
        timer_d    = '0;
        done_d     = 1'b0;
        invalid_d  = 1'b0;
        timeout_d  = 1'b0;

        if (start) begin
            // New game wins over everything; any in-flight move is discarded.
            state_d    = StWait;
            board_d    = '0;
            cur_d      = FIRST_PLAYER;
            count_d    = '0;
            last_row_d = 3'd7;
            last_col_d = 3'd7;
        end else begin
            case (state_q)
                StIdle: ;
                StWait: begin
                    if (game_over) begin
                        state_d = StOver;
                    end else if (move_req) begin
                        val_col_d = move_col;
                        state_d   = StCheck;
                    end else if (timer_q == TIMER_LAST) begin
                        timeout_d = 1'b1;
                        cur_d     = other_player;
                    end else begin
                        timer_d = timer_q + TIMER_W'(1);
                    end
                end
                StCheck: begin
                    // Column guard keeps a misbehaving validator from indexing off the board.
                    if (val_valid && (val_row <= 3'd5) && (val_col_q <= 3'd6)) begin
                        row_d   = val_row;
                        state_d = StWrite;
                    end else begin
                        invalid_d = 1'b1;
                        state_d   = StWait;
                    end
                end
                StWrite: begin
                    board_d[row_q][val_col_q] = cur_q;
                    last_row_d = row_q;
                    last_col_d = val_col_q;
                    count_d    = (count_q < CELLS) ? count_q + 6'd1 : count_q;
                    done_d     = 1'b1;
                    cur_d      = other_player;
                    state_d    = StSettle;
                end
                StSettle: begin
                    state_d = (game_over || (count_q == CELLS)) ? StOver : StWait;
                end
                StOver: ;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            board_q    <= '0;
            cur_q      <= FIRST_PLAYER;
            count_q    <= '0;
            last_row_q <= 3'd7;
            last_col_q <= 3'd7;
            val_col_q  <= '0;
            row_q      <= '0;
            timer_q    <= '0;
            done_q     <= 1'b0;
            invalid_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            board_q    <= board_d;
            cur_q      <= cur_d;
            count_q    <= count_d;
            last_row_q <= last_row_d;
            last_col_q <= last_col_d;
            val_col_q  <= val_col_d;
            row_q      <= row_d;
            timer_q    <= timer_d;
            done_q     <= done_d;
            invalid_q  <= invalid_d;
            timeout_q  <= timeout_d;
        end
    end

    assign val_col      = val_col_q;
    assign board        = board_q;
    assign cur_player   = cur_q;
    assign busy         = (state_q == StCheck) || (state_q == StWrite);
    assign move_done    = done_q;
    assign move_invalid = invalid_q;
    assign turn_timeout = timeout_q;
    assign last_row     = last_row_q;
    assign last_col     = last_col_q;
    assign move_count   = count_q;
    assign board_full   = (count_q == CELLS);

endmodule
